// File: rtl/acorn128_pkg.sv
// Shared constants, FSM encoding and the ACORN-128 boolean helpers
// used by the step datapath and the finalization controller.
package acorn128_pkg;

    localparam int STATE_W     = 293;
    localparam int FINAL_STEPS = 768;
    localparam int TAG_W       = 128;
    localparam int TAG_START   = 640;
    localparam int CNT_W       = 10;

    // Taps of the six LFSR junctions, the keystream and the feedback
    localparam int T_S0   = 0;
    localparam int T_S12  = 12;
    localparam int T_S23  = 23;
    localparam int T_S61  = 61;
    localparam int T_S66  = 66;
    localparam int T_S107 = 107;
    localparam int T_S111 = 111;
    localparam int T_S154 = 154;
    localparam int T_S160 = 160;
    localparam int T_S193 = 193;
    localparam int T_S196 = 196;
    localparam int T_S230 = 230;
    localparam int T_S235 = 235;
    localparam int T_S244 = 244;
    localparam int T_S289 = 289;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fin_state_e;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

    // Expects the state after the six junction updates of the current step
    function automatic logic acorn_ks(input logic [STATE_W-1:0] s);
        return s[T_S12] ^ s[T_S154] ^ maj(s[T_S235], s[T_S61], s[T_S193])
             ^ ch(s[T_S230], s[T_S111], s[T_S66]);
    endfunction

    function automatic logic acorn_fb(input logic [STATE_W-1:0] s, input logic ca,
                                      input logic cb, input logic m, input logic ks);
        return s[T_S0] ^ ~s[T_S107] ^ maj(s[T_S244], s[T_S23], s[T_S160])
             ^ (ca & s[T_S196]) ^ (cb & ks) ^ m;
    endfunction

endpackage

// File: rtl/acorn128_step.sv
// One combinational ACORN-128 state update: junction mixing, keystream,
// feedback and shift. Chained to unroll several steps per clock.
module acorn128_step
    import acorn128_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic               ca_i,
    input  logic               cb_i,
    input  logic               m_i,
    output logic [STATE_W-1:0] state_o,
    output logic               ks_o
);

    logic [STATE_W-1:0] mix_s;
    logic               ks_s;
    logic               fb_s;

    // Each junction reads only bits that are updated later in the sequence,
    // so all right-hand sides can use the incoming state directly.
    always_comb begin
        mix_s          = state_i;
        mix_s[T_S289]  = state_i[T_S289] ^ state_i[T_S235] ^ state_i[T_S230];
        mix_s[T_S230]  = state_i[T_S230] ^ state_i[T_S196] ^ state_i[T_S193];
        mix_s[T_S193]  = state_i[T_S193] ^ state_i[T_S160] ^ state_i[T_S154];
        mix_s[T_S154]  = state_i[T_S154] ^ state_i[T_S111] ^ state_i[T_S107];
        mix_s[T_S107]  = state_i[T_S107] ^ state_i[T_S66]  ^ state_i[T_S61];
        mix_s[T_S61]   = state_i[T_S61]  ^ state_i[T_S23]  ^ state_i[T_S0];
        ks_s           = acorn_ks(mix_s);
        fb_s           = acorn_fb(mix_s, ca_i, cb_i, m_i, ks_s);
        state_o        = {fb_s, mix_s[STATE_W-1:1]};
        ks_o           = ks_s;
    end

endmodule

// File: rtl/finalization.sv
// ACORN-128 finalization: 768 steps with ca=cb=1, m=0 on a loaded state,
// collecting the last 128 keystream bits as the tag.
module finalization
    import acorn128_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
    output logic               busy,
    output logic               tag_valid,
    output logic [TAG_W-1:0]   tag_out,
    output logic [STATE_W-1:0] state_out
);

    localparam int               P        = STEPS_PER_CYCLE;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FINAL_STEPS - P);
    localparam logic [CNT_W-1:0] CNT_TAG  = CNT_W'(TAG_START);
    localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(P);

    fin_state_e         fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               tag_valid_q, tag_valid_d;
    logic               busy_q, busy_d;

    logic [STATE_W-1:0] chain_s [0:P];
    logic [P-1:0]       ks_s;

    assign chain_s[0] = state_q;

    for (genvar g = 0; g < P; g++) begin : g_step
        acorn128_step u_step (
            .state_i (chain_s[g]),
            .ca_i    (1'b1),
            .cb_i    (1'b1),
            .m_i     (1'b0),
            .state_o (chain_s[g+1]),
            .ks_o    (ks_s[g])
        );
    end

    // Next-state logic; the tag fills from the top so the earliest
    // collected bit ends up in tag bit 0 once 128 bits have been shifted in.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        busy_d      = busy_q;
        case (fsm_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    fsm_d       = ST_RUN;
                    state_d     = state_in;
                    cnt_d       = {CNT_W{1'b0}};
                    tag_d       = {TAG_W{1'b0}};
                    tag_valid_d = 1'b0;
                    busy_d      = 1'b1;
                end else begin
                    fsm_d       = fsm_q;
                end
            end
            ST_RUN: begin
                state_d = chain_s[P];
                cnt_d   = cnt_q + CNT_INC;
                if (cnt_q >= CNT_TAG) begin
                    tag_d = {ks_s, tag_q[TAG_W-1:P]};
                end else begin
                    tag_d = tag_q;
                end
                if (cnt_q == CNT_LAST) begin
                    fsm_d       = ST_DONE;
                    tag_valid_d = 1'b1;
                    busy_d      = 1'b0;
                end else begin
                    fsm_d       = ST_RUN;
                end
            end
            default: begin
                fsm_d       = ST_IDLE;
                busy_d      = 1'b0;
                tag_valid_d = 1'b0;
            end
        endcase
    end

    // State, counter, tag and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            state_q     <= {STATE_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            tag_q       <= {TAG_W{1'b0}};
            tag_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign tag_valid = tag_valid_q;
    assign tag_out   = tag_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_finalization.sv
// Bench for finalization: four instances (1,2,4,8 steps per clock) checked
// against an independent bit-serial ACORN-128 model through a scoreboard.
module tb_finalization;

    localparam int SW = 293;
    localparam int TW = 128;
    localparam int NI = 4;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [SW-1:0] st;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [SW-1:0] state_in;
    logic          start_v   [NI];
    logic          busy_v    [NI];
    logic          tag_valid_v [NI];
    logic [TW-1:0] tag_v     [NI];
    logic [SW-1:0] st_v      [NI];

    exp_t sb_q [NI][$];
    int   n_checks;
    int   n_fail;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        finalization #(.STEPS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_v[g]),
            .state_in  (state_in),
            .busy      (busy_v[g]),
            .tag_valid (tag_valid_v[g]),
            .tag_out   (tag_v[g]),
            .state_out (st_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SW-1:0] ref_step(input logic [SW-1:0] s_in, input logic ca,
                                               input logic cb, input logic m, output logic ks);
        logic [SW-1:0] s;
        logic          f;
        logic          mj;
        s      = s_in;
        s[289] = s[289] ^ s[235] ^ s[230];
        s[230] = s[230] ^ s[196] ^ s[193];
        s[193] = s[193] ^ s[160] ^ s[154];
        s[154] = s[154] ^ s[111] ^ s[107];
        s[107] = s[107] ^ s[66]  ^ s[61];
        s[61]  = s[61]  ^ s[23]  ^ s[0];
        mj = (s[235] & s[61]) | (s[235] & s[193]) | (s[61] & s[193]);
        ks = s[12] ^ s[154] ^ mj ^ (s[230] ? s[111] : s[66]);
        mj = (s[244] & s[23]) | (s[244] & s[160]) | (s[23] & s[160]);
        f  = s[0] ^ ~s[107] ^ mj ^ (ca & s[196]) ^ (cb & ks) ^ m;
        return {f, s[SW-1:1]};
    endfunction

    function automatic exp_t ref_final(input logic [SW-1:0] sin);
        exp_t e;
        logic ks;
        e.st  = sin;
        e.tag = '0;
        for (int k = 0; k < 768; k++) begin
            e.st = ref_step(e.st, 1'b1, 1'b1, 1'b0, ks);
            if (k >= 640) e.tag[k-640] = ks;
        end
        return e;
    endfunction

    // State after init, empty AD and empty plaintext for key=0, IV=0
    function automatic logic [SW-1:0] kat_state();
        logic [SW-1:0] s;
        logic          ks;
        s = '0;
        for (int i = 0; i < 1792; i++) s = ref_step(s, 1'b1, 1'b1, (i == 256), ks);
        for (int i = 0; i < 256; i++)  s = ref_step(s, (i < 128), 1'b1, (i == 0), ks);
        for (int i = 0; i < 256; i++)  s = ref_step(s, (i < 128), 1'b0, (i == 0), ks);
        return s;
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] r;
        for (int i = 0; i < SW; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic check_idle_outputs(input string name);
        for (int g = 0; g < NI; g++) begin
            n_checks += 4;
            if (busy_v[g] !== 1'b0) begin
                n_fail++; $display("FAIL %s busy[%0d]: got %b want 0", name, g, busy_v[g]);
            end
            if (tag_valid_v[g] !== 1'b0) begin
                n_fail++; $display("FAIL %s tag_valid[%0d]: got %b want 0", name, g, tag_valid_v[g]);
            end
            if (tag_v[g] !== '0) begin
                n_fail++; $display("FAIL %s tag_out[%0d]: got %h want 0", name, g, tag_v[g]);
            end
            if (st_v[g] !== '0) begin
                n_fail++; $display("FAIL %s state_out[%0d]: got %h want 0", name, g, st_v[g]);
            end
        end
    endtask

    // Start the instances in mask with sin, optionally re-pulse start with
    // all-ones at cycle ignore_at, then check timing and scoreboard results.
    task automatic launch(input logic [NI-1:0] mask, input logic [SW-1:0] sin,
                          input int ignore_at, input string name);
        int   busy_cnt [NI];
        int   done_at  [NI];
        exp_t e;
        e = ref_final(sin);
        for (int g = 0; g < NI; g++) begin
            busy_cnt[g] = 0;
            done_at[g]  = 0;
            if (mask[g]) sb_q[g].push_back(e);
        end
        @(negedge clk);
        state_in = sin;
        for (int g = 0; g < NI; g++) start_v[g] = mask[g];
        @(negedge clk);
        for (int cyc = 0; cyc <= 800; cyc++) begin
            for (int g = 0; g < NI; g++) begin
                if (mask[g]) begin
                    if (cyc == 0) begin
                        n_checks++;
                        if (tag_valid_v[g] !== 1'b0 || busy_v[g] !== 1'b1) begin
                            n_fail++;
                            $display("FAIL %s accept[%0d]: got busy=%b tag_valid=%b want busy=1 tag_valid=0",
                                     name, g, busy_v[g], tag_valid_v[g]);
                        end
                    end
                    if (busy_v[g] === 1'b1) busy_cnt[g]++;
                    if (tag_valid_v[g] === 1'b1 && done_at[g] == 0) done_at[g] = cyc;
                end
            end
            if (cyc == 0) begin
                for (int g = 0; g < NI; g++) start_v[g] = 1'b0;
                state_in = rand_state();
            end
            if (cyc == ignore_at - 1) begin
                state_in = '1;
                for (int g = 0; g < NI; g++) start_v[g] = mask[g];
            end
            if (cyc == ignore_at) begin
                for (int g = 0; g < NI; g++) start_v[g] = 1'b0;
            end
            @(negedge clk);
        end
        for (int g = 0; g < NI; g++) begin
            if (mask[g]) begin
                n_checks += 5;
                if (busy_cnt[g] != (768 >> g)) begin
                    n_fail++; $display("FAIL %s busy_cycles[%0d]: got %0d want %0d", name, g, busy_cnt[g], 768 >> g);
                end
                if (done_at[g] != (768 >> g)) begin
                    n_fail++; $display("FAIL %s done_edge[%0d]: got %0d want %0d", name, g, done_at[g], 768 >> g);
                end
                if (tag_valid_v[g] !== 1'b1) begin
                    n_fail++; $display("FAIL %s tag_valid_hold[%0d]: got %b want 1", name, g, tag_valid_v[g]);
                end
                if (sb_q[g].size() == 0) begin
                    n_fail += 2; $display("FAIL %s scoreboard[%0d]: got empty queue want entry", name, g);
                end else begin
                    e = sb_q[g].pop_front();
                    if (tag_v[g] !== e.tag) begin
                        n_fail++; $display("FAIL %s tag[%0d]: got %h want %h", name, g, tag_v[g], e.tag);
                    end
                    if (st_v[g] !== e.st) begin
                        n_fail++; $display("FAIL %s state[%0d]: got %h want %h", name, g, st_v[g], e.st);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");
    endtask

    task automatic test_latency();
        launch(4'b1111, '0, -1, "latency_zero_state");
    endtask

    task automatic test_known_answer();
        logic [SW-1:0] ks_state;
        ks_state = kat_state();
        $display("KAT reference tag = %h", ref_final(ks_state).tag);
        launch(4'b1111, ks_state, -1, "known_answer");
    endtask

    task automatic test_start_ignored();
        launch(4'b0001, rand_state(), 100, "start_ignored");
    endtask

    task automatic test_reset_midrun();
        int pulses;
        pulses = 0;
        @(negedge clk);
        state_in   = rand_state();
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (tag_valid_v[0] === 1'b1) pulses++;
            @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_midrun_async");
        n_checks++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL reset_midrun tag_valid_pulses: got %0d want 0", pulses);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_midrun_held");
        launch(4'b1111, rand_state(), -1, "after_reset_midrun");
    endtask

    task automatic test_back_to_back();
        launch(4'b1111, rand_state(), -1, "back_to_back_1");
        launch(4'b1111, rand_state(), -1, "back_to_back_2");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        state_in = '0;
        for (int g = 0; g < NI; g++) start_v[g] = 1'b0;
        test_reset();
        test_latency();
        test_known_answer();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
